// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and trace formatting for the CPU core
package cpu_pkg;

  // Architectural defaults for the general-purpose register file.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Index of the hard-wired zero register.
  localparam int REG_ZERO = 0;

  // One write-commit trace line: "time@pc: $addr <= data".
  function automatic string trace_line(input logic [63:0] t,
                                       input logic [31:0] pc,
                                       input logic [31:0] addr,
                                       input logic [63:0] data);
    return $sformatf("%0t@%08h: $%0d <= %0h", t, pc, addr, data);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - bypass, zero and busy mux for one register read port
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wr_en,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic is_zero;
  logic wr_hit;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));
  assign wr_hit  = wr_en && (wr_addr == rd_addr);

  // Zero register first, then same-cycle write bypass, then stored value;
  // a same-cycle write to the addressed register releases the hazard.
  always_comb begin
    rd_data = stored_data;
    rd_busy = stored_busy && !wr_hit;
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (wr_hit && wr_commit) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and busy scoreboard
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int TRACE    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [31:0]            wr_pc,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  input  logic                   flush,
  output logic [ADDR_W:0]        busy_cnt,
  output logic                   claim_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              claim_ovf_q, claim_ovf_d;

  logic wr_commit;
  logic claim_eff;
  logic same_addr;
  logic bit_set;
  logic bit_clr;

  // Writes and claims to the zero register are discarded entirely.
  assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
  assign claim_eff = claim_en && !((ZERO_REG != 0) && (claim_addr == ADDR_W'(REG_ZERO)));
  assign same_addr = wr_commit && claim_eff && (wr_addr == claim_addr);

  // A claim only adds to the population if the bit was clear; a write only
  // removes one if the bit was set and no claim re-arms it on the same edge.
  assign bit_set = claim_eff && !busy_q[claim_addr];
  assign bit_clr = wr_commit && busy_q[wr_addr] && !same_addr;

  // Register storage next state: committed write lands on its register.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Scoreboard next state: flush or write release, then claim re-arms.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else if (wr_commit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_eff) begin
      busy_d[claim_addr] = 1'b1;
    end
  end

  // Busy population count, maintained incrementally rather than by popcount.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      busy_cnt_d = claim_eff ? (ADDR_W + 1)'(1) : '0;
    end else if (bit_set && !bit_clr) begin
      busy_cnt_d = busy_cnt_q + (ADDR_W + 1)'(1);
    end else if (bit_clr && !bit_set) begin
      busy_cnt_d = busy_cnt_q - (ADDR_W + 1)'(1);
    end
  end

  // Sticky overflow: claiming a register that stays busy through this edge.
  always_comb begin
    claim_ovf_d = claim_ovf_q;
    if (claim_eff && busy_q[claim_addr] && !flush &&
        !(wr_commit && (wr_addr == claim_addr))) begin
      claim_ovf_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      claim_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      claim_ovf_q <= claim_ovf_d;
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign claim_ovf = claim_ovf_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .rd_addr     (addr_k),
      .stored_data (regs_q[addr_k]),
      .stored_busy (busy_q[addr_k]),
      .wr_en       (wr_en),
      .wr_commit   (wr_commit),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy     (rd_busy[k])
    );
  end

`ifndef SYNTHESIS
  if (TRACE != 0) begin : g_trace
    // Report each committed write once, on the edge that commits it.
    always_ff @(posedge clk) begin
      if (!reset && wr_commit) begin
        $display("%s", trace_line($time, wr_pc, 32'(wr_addr), 64'(wr_data)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic                  clk;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [31:0]           wr_pc;
  logic                  claim_en;
  logic [ADDR_W-1:0]     claim_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;
  logic                  claim_ovf;

  int n_vec;
  int n_mis;

  regfile_sb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (1),
    .TRACE    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_pc      (wr_pc),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy_cnt   (busy_cnt),
    .claim_ovf  (claim_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    wr_en = 1'b0; claim_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_mis = 0;
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_pc = 32'h0000_1000; claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // Reset state on every register, both ports
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      chk($sformatf("rst_data0_r%0d", i), 64'(rd_data[31:0]), 64'h0);
      chk($sformatf("rst_data1_r%0d", 31 - i), 64'(rd_data[63:32]), 64'h0);
      chk($sformatf("rst_busy_r%0d", i), 64'(rd_busy), 64'h0);
    end
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_claim_ovf", 64'(claim_ovf), 64'd0);

    // Write r5 with same-cycle bypass on port 0
    set_rd(5'd5, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_pc = 32'h0000_1004;
    #1;
    chk("bypass_r5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    tick();
    idle();
    #1;
    chk("stored_r5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);

    // Write r0 is discarded
    set_rd(5'd0, 5'd5);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; wr_pc = 32'h0000_1008;
    #1;
    chk("r0_bypass_blocked", 64'(rd_data[31:0]), 64'h0);
    tick();
    idle();
    #1;
    chk("r0_stored", 64'(rd_data[31:0]), 64'h0);
    chk("r0_busy_cnt", 64'(busy_cnt), 64'd0);

    // Claim r3 then r7, hazard on r3 released by same-cycle write
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    chk("claim_r3_cnt", 64'(busy_cnt), 64'd1);
    claim_addr = 5'd7;
    tick();
    chk("claim_r7_cnt", 64'(busy_cnt), 64'd2);
    idle();
    set_rd(5'd7, 5'd3);
    #1;
    chk("r3_busy_p1", 64'(rd_busy[1]), 64'd1);
    chk("r7_busy_p0", 64'(rd_busy[0]), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1; wr_pc = 32'h0000_100C;
    #1;
    chk("r3_busy_released", 64'(rd_busy[1]), 64'd0);
    chk("r3_bypass", 64'(rd_data[63:32]), 64'h1);
    tick();
    idle();
    #1;
    chk("r3_write_cnt", 64'(busy_cnt), 64'd1);
    chk("r3_busy_after", 64'(rd_busy[1]), 64'd0);

    // r9 claimed, then claimed again together with its write: no overflow
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    chk("claim_r9_cnt", 64'(busy_cnt), 64'd2);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5; wr_pc = 32'h0000_1010;
    tick();
    idle();
    set_rd(5'd9, 5'd9);
    #1;
    chk("r9_data", 64'(rd_data[31:0]), 64'hA5);
    chk("r9_busy", 64'(rd_busy[0]), 64'd1);
    chk("r9_cnt_same", 64'(busy_cnt), 64'd2);
    chk("r9_no_ovf", 64'(claim_ovf), 64'd0);
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    idle();
    #1;
    chk("r9_ovf", 64'(claim_ovf), 64'd1);
    chk("r9_ovf_cnt", 64'(busy_cnt), 64'd2);

    // Claim r2, r4, r6, then flush with a claim of r8
    claim_en = 1'b1; claim_addr = 5'd2;
    tick();
    claim_addr = 5'd4;
    tick();
    claim_addr = 5'd6;
    tick();
    chk("three_claims_cnt", 64'(busy_cnt), 64'd5);
    flush = 1'b1; claim_addr = 5'd8;
    tick();
    idle();
    set_rd(5'd8, 5'd2);
    #1;
    chk("flush_cnt", 64'(busy_cnt), 64'd1);
    chk("flush_r8_busy", 64'(rd_busy[0]), 64'd1);
    chk("flush_r2_free", 64'(rd_busy[1]), 64'd0);
    chk("flush_ovf_sticky", 64'(claim_ovf), 64'd1);

    // Reset mid-sequence overrides a concurrent claim and write
    reset = 1'b1; claim_en = 1'b1; claim_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h77;
    tick();
    reset = 1'b0;
    idle();
    set_rd(5'd5, 5'd8);
    #1;
    chk("rst2_cnt", 64'(busy_cnt), 64'd0);
    chk("rst2_ovf", 64'(claim_ovf), 64'd0);
    chk("rst2_r5", 64'(rd_data[31:0]), 64'h0);
    chk("rst2_r8_busy", 64'(rd_busy[1]), 64'd0);
    set_rd(5'd12, 5'd10);
    #1;
    chk("rst2_r12", 64'(rd_data[31:0]), 64'h0);
    chk("rst2_r10_busy", 64'(rd_busy[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU core: configurable data width, depth and read-port count.
- Write-to-read bypass: a value being written is visible on the same cycle's reads.
- Per-register busy scoreboard, so decode can detect pending writes and stall.
- Sits between decode (reads, claims) and writeback (writes, busy release).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, if 1 then register 0 reads 0, ignores writes and is never busy.
- TRACE, 1, if 1 then every committed write prints "time@pc: $addr <= data" (simulation only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  packed read data, combinational.
- rd_busy  out  NRD  per-port busy flag for the addressed register, combinational.
- wr_en  in  1  writeback write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_pc  in  32  PC of the writing instruction, used for trace only.
- claim_en  in  1  decode issues an instruction with a destination; marks it busy.
- claim_addr  in  ADDR_W  destination being claimed.
- flush  in  1  pipeline flush; clears all busy bits.
- busy_cnt  out  ADDR_W+1  number of currently busy registers, registered.
- claim_ovf  out  1  sticky error flag: claim was made to an already-busy register.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - All registers become 0; all busy bits become 0; busy_cnt=0; claim_ovf=0.
  - Reset overrides wr_en, claim_en and flush in the same cycle.
- Write:
  - When wr_en=1 (and not (ZERO_REG and wr_addr==0)), the register is updated at posedge.
  - The same edge clears busy[wr_addr].
  - TRACE prints once per committed write, never for writes to r0 when ZERO_REG=1.
- Read (combinational, per port k):
  - If ZERO_REG and addr==0, data=0.
  - Else if wr_en and wr_addr==addr (and the write is not discarded), data=wr_data (bypass).
  - Else data=stored value.
- rd_busy[k] = busy[addr] AND NOT (wr_en and wr_addr==addr). A same-cycle write releases the hazard combinationally. r0 is always 0 when ZERO_REG=1.
- Claim:
  - claim_en sets busy[claim_addr] at posedge; ignored for r0 when ZERO_REG=1.
  - Claiming an already-busy register not released that same cycle sets claim_ovf (sticky until reset). The bit stays set.
- Simultaneous claim and write to the same address: the write commits data and the claim wins, so the busy bit ends at 1 and busy_cnt is unchanged.
- Flush clears all busy bits at posedge and busy_cnt→0.
  - A claim in the same cycle as flush is honoured afterwards: the final state is only that bit set, busy_cnt=1.
  - A write in the same cycle as flush still commits its data.
- busy_cnt tracks the population of the busy vector: +1 per newly set bit, −1 per cleared bit, net per cycle (−1/0/+1 except on flush). It never wraps; the maximum is 2**ADDR_W − ZERO_REG.
- Writes to non-busy registers are legal (no error) and leave busy unchanged.

Decomposition:
- Shared package cpu_pkg: REG_ZERO address constant, DATA_W/ADDR_W defaults, trace format string.
- One natural sub-module, regfile_read_port: the bypass, zero and busy mux for one port, instantiated NRD times via generate.
- Storage, scoreboard and counter stay in the top level.

Test Plan:
- Reset then read all 32 registers on both ports -> every rd_data=0, rd_busy=0, busy_cnt=0, claim_ovf=0.
- Write r5=0xDEADBEEF while port0 reads r5 in the same cycle -> rd_data0=0xDEADBEEF that cycle (bypass); still 0xDEADBEEF the next cycle; one trace line.
- Write r0=0x12345678 with ZERO_REG=1 -> r0 reads 0, no trace line, busy_cnt stays 0.
- Claim r3, then r7 -> busy_cnt 1, then 2. Port1 reads r3 -> rd_busy1=1. Write r3=0x1 -> rd_busy1=0 in the same cycle; busy_cnt=1 next cycle.
- Claim r9 and write r9=0xA5 in the same cycle (r9 previously busy) -> r9=0xA5, busy[9]=1, busy_cnt unchanged, claim_ovf=0. A second claim of r9 -> claim_ovf=1.
- Claim r2, r4, r6; then flush together with claim r8 -> busy_cnt=1, only r8 busy. Assert reset mid-sequence -> all state 0 on the next edge.
